// File: rtl/utils_pkg.sv
// Shared types for the instruction fetch path.
//   pc_t / instr_raw_t  : 32-bit program counter and raw instruction word
//   valid_t / ready_t   : handshake qualifiers toward decode
//   s_ibus_req_t        : instruction bus request {req, addr}
//   s_ibus_rsp_t        : instruction bus response {gnt, rvalid, rdata, err}
//   INSTR_NOP           : canonical NOP that decode substitutes for faulting fetches
package utils_pkg;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] instr_raw_t;
  typedef logic        valid_t;
  typedef logic        ready_t;

  typedef struct packed {
    logic req;
    pc_t  addr;
  } s_ibus_req_t;

  typedef struct packed {
    logic       gnt;
    logic       rvalid;
    instr_raw_t rdata;
    logic       err;
  } s_ibus_rsp_t;

  localparam instr_raw_t INSTR_NOP = 32'h0000_0013;
  localparam pc_t        PC_STEP   = 32'd4;

endpackage

// File: rtl/fifo_nox.sv
// Generic synchronous FIFO with a synchronous flush.
//   clk, rst     : clock, asynchronous active-low reset (pointers/count only)
//   flush_i      : empties the FIFO at the next edge; wins over push/pop
//   push_i/data_i: write one entry (a push on a full FIFO is accepted only with a pop)
//   pop_i        : remove the head entry
//   data_o       : head entry (meaningless while empty_o)
//   empty_o      : no entries stored
//   count_o      : number of stored entries
module fifo_nox #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop frees the slot being written, so full+push+pop is legal.
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding decode.
//   clk, rst            : core clock, asynchronous active-low reset
//   pc_reset_i          : boot address, loaded in the first cycle after reset release
//   jump_i, pc_jump_i   : one-cycle redirect request and its target
//   ibus_req_o/addr_o   : read request, held stable until granted
//   ibus_gnt_i          : request accepted this cycle
//   ibus_rvalid_i/rdata_i/err_i : in-order read response
//   fetch_valid_o/ready_i : handshake to decode
//   fetch_instr_o       : head instruction (zero for a faulting fetch)
//   fetch_err_o         : head entry is an instruction access fault
module fetch_unit
  import utils_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  pc_t        pc_reset_i,
  input  logic       jump_i,
  input  pc_t        pc_jump_i,
  output logic       ibus_req_o,
  output pc_t        ibus_addr_o,
  input  logic       ibus_gnt_i,
  input  logic       ibus_rvalid_i,
  input  instr_raw_t ibus_rdata_i,
  input  logic       ibus_err_i,
  output valid_t     fetch_valid_o,
  input  ready_t     fetch_ready_i,
  output instr_raw_t fetch_instr_o,
  output logic       fetch_err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  s_ibus_req_t   req;
  s_ibus_rsp_t   rsp;

  logic          run_q;
  pc_t           pc_q, pc_d;
  pc_t           hold_addr_q;
  logic          pend_q, pend_d;
  logic          stale_q, stale_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;

  logic [CW-1:0] q_count;
  logic          q_empty;
  logic [32:0]   q_head;

  logic          credit_ok, grant, resp, drop, push, pop, stale_grant;

  assign rsp = {ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i, ibus_err_i};

  // Every in-flight read owns a queue slot, so a response can always be stored.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, q_count}) < SW'(FIFO_DEPTH);

  // run_q keeps the bus quiet during the cycle pc_q is loaded from pc_reset_i.
  assign req.req  = run_q && (pend_q || credit_ok);
  // An ungranted request keeps its address even across a redirect.
  assign req.addr = pend_q ? hold_addr_q : pc_q;

  assign ibus_req_o  = req.req;
  assign ibus_addr_o = req.addr;

  assign grant       = req.req && rsp.gnt;
  // With nothing outstanding, a response is left over from before reset.
  assign resp        = rsp.rvalid && (outst_q != '0);
  assign drop        = resp && (disc_q != '0);
  assign push        = resp && !drop && !jump_i;
  assign pop         = fetch_valid_o && fetch_ready_i;
  // Granting a request issued before a redirect fetches a word nobody wants.
  assign stale_grant = grant && pend_q && stale_q;

  always_comb begin
    outst_d = outst_q;
    if (grant && !resp)      outst_d = outst_q + CW'(1);
    else if (!grant && resp) outst_d = outst_q - CW'(1);

    disc_d = disc_q;
    if (drop)        disc_d = disc_d - CW'(1);
    if (stale_grant) disc_d = disc_d + CW'(1);
    // Everything still in flight after this cycle belongs to the old stream.
    if (jump_i)      disc_d = outst_d;

    pc_d = pc_q;
    if (jump_i)                     pc_d = pc_jump_i;
    else if (!run_q)                pc_d = pc_reset_i;
    else if (grant && !stale_grant) pc_d = pc_q + PC_STEP;

    pend_d  = req.req && !rsp.gnt;
    stale_d = pend_d && (stale_q || jump_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q       <= 1'b0;
      pc_q        <= '0;
      hold_addr_q <= '0;
      pend_q      <= 1'b0;
      stale_q     <= 1'b0;
      outst_q     <= '0;
      disc_q      <= '0;
    end else begin
      run_q       <= 1'b1;
      pc_q        <= pc_d;
      hold_addr_q <= req.addr;
      pend_q      <= pend_d;
      stale_q     <= stale_d;
      outst_q     <= outst_d;
      disc_q      <= disc_d;
    end
  end

  fifo_nox #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (jump_i),
    .push_i  (push),
    .data_i  ({rsp.err, rsp.rdata}),
    .pop_i   (pop),
    .data_o  (q_head),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign fetch_valid_o = !q_empty;
  assign fetch_err_o   = !q_empty && q_head[32];
  assign fetch_instr_o = (q_empty || q_head[32]) ? '0 : q_head[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] DKEY  = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_reset_i;
  logic        jump_i;
  logic [31:0] pc_jump_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i  = '0;
  logic        ibus_err_i    = 1'b0;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_instr_o;
  logic        fetch_err_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr [$];
  logic [32:0] exp_instr[$];
  logic [31:0] bus_q    [$];
  int          gnt_budget = 0;
  bit          rsp_hold   = 1'b0;
  logic [31:0] err_addr   = 32'h0000_0002;

  fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_reset_i    (pc_reset_i),
    .jump_i        (jump_i),
    .pc_jump_i     (pc_jump_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .ibus_err_i    (ibus_err_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_ready_i (fetch_ready_i),
    .fetch_instr_o (fetch_instr_o),
    .fetch_err_o   (fetch_err_o)
  );

  always #5 clk = ~clk;

  assign ibus_gnt_i = (gnt_budget > 0);

  // Memory model: data word = address ^ DKEY; err on err_addr; one-cycle latency, in order.
  always @(posedge clk) begin
    logic        g;
    logic [31:0] a;
    logic [31:0] r;
    g = ibus_req_o && ibus_gnt_i;
    a = ibus_addr_o;
    #1;
    if (g) begin
      bus_q.push_back(a);
      gnt_budget--;
    end
    if (!rsp_hold && bus_q.size() > 0) begin
      r = bus_q.pop_front();
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = r ^ DKEY;
      ibus_err_i    = (r == err_addr);
    end else begin
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = '0;
      ibus_err_i    = 1'b0;
    end
  end

  // Monitor: grant addresses, delivered words, request hold stability.
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [32:0] ew;
    if (!rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        checks++;
        if (!(ibus_req_o && ibus_addr_o == prev_addr)) begin
          errors++;
          $display("FAIL req_hold: req=%0b addr=%h, held request was %h", ibus_req_o, ibus_addr_o, prev_addr);
        end
      end
      if (ibus_req_o && ibus_gnt_i) begin
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL grant_addr: got %h, no grant expected", ibus_addr_o);
        end else begin
          ea = exp_addr.pop_front();
          if (ibus_addr_o !== ea) begin
            errors++;
            $display("FAIL grant_addr: got %h expected %h", ibus_addr_o, ea);
          end
        end
      end
      if (fetch_valid_o && fetch_ready_i) begin
        checks++;
        if (exp_instr.size() == 0) begin
          errors++;
          $display("FAIL fetch_word: got err=%0b instr=%h, no delivery expected", fetch_err_o, fetch_instr_o);
        end else begin
          ew = exp_instr.pop_front();
          if ({fetch_err_o, fetch_instr_o} !== ew) begin
            errors++;
            $display("FAIL fetch_word: got err=%0b instr=%h expected err=%0b instr=%h",
                     fetch_err_o, fetch_instr_o, ew[32], ew[31:0]);
          end
        end
      end
      prev_pend = ibus_req_o && !ibus_gnt_i;
      prev_addr = ibus_addr_o;
    end
  end

  function automatic logic [32:0] word_of(input logic [31:0] a);
    return (a == err_addr) ? {1'b1, 32'h0} : {1'b0, a ^ DKEY};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] a, input int n, input bit deliver);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(a + 32'(4 * i));
      if (deliver) exp_instr.push_back(word_of(a + 32'(4 * i)));
    end
  endtask

  task automatic grant(input int n);
    gnt_budget += n;
  endtask

  task automatic wait_drain(input string name, input int max);
    int k = 0;
    while ((exp_addr.size() != 0 || exp_instr.size() != 0 || bus_q.size() != 0) && k < max) begin
      cyc(1);
      k++;
    end
    checks++;
    if (k >= max) begin
      errors++;
      $display("FAIL %s: timeout, %0d grants and %0d words still expected", name,
               exp_addr.size(), exp_instr.size());
    end
  endtask

  task automatic wait_budget(input string name, input int max);
    int k = 0;
    while (gnt_budget != 0 && k < max) begin
      cyc(1);
      k++;
    end
    checks++;
    if (k >= max) begin
      errors++;
      $display("FAIL %s: timeout, %0d grants not taken", name, gnt_budget);
    end
  endtask

  task automatic do_jump(input logic [31:0] t);
    jump_i    = 1'b1;
    pc_jump_i = t;
    cyc(1);
    jump_i    = 1'b0;
    check("valid_after_jump", {31'b0, fetch_valid_o}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'b0, ibus_req_o},    32'd0);
    check({tag, "_valid"}, {31'b0, fetch_valid_o}, 32'd0);
    check({tag, "_err"},   {31'b0, fetch_err_o},   32'd0);
    check({tag, "_instr"}, fetch_instr_o,          32'd0);
  endtask

  initial begin
    rst           = 1'b0;
    jump_i        = 1'b0;
    pc_jump_i     = '0;
    pc_reset_i    = 32'h8000_0000;
    fetch_ready_i = 1'b1;
    cyc(3);
    check_reset_outputs("reset");

    // Boot, streaming fetch, and a bus error on the second word.
    rst = 1'b1;
    check("req_before_first_edge", {31'b0, ibus_req_o}, 32'd0);
    cyc(1);
    check("first_req", {31'b0, ibus_req_o}, 32'd1);
    check("first_addr", ibus_addr_o, 32'h8000_0000);
    err_addr = 32'h8000_0004;
    expect_fetch(32'h8000_0000, 6, 1'b1);
    grant(6);
    wait_drain("stream", 200);
    err_addr = 32'h0000_0002;

    // Decode stalled: credit limits grants to DEPTH, then fetching resumes.
    fetch_ready_i = 1'b0;
    expect_fetch(32'h8000_0018, 2, 1'b0);
    grant(10);
    cyc(10);
    check("req_when_full", {31'b0, ibus_req_o}, 32'd0);
    gnt_budget = 0;
    exp_instr.push_back(word_of(32'h8000_0018));
    exp_instr.push_back(word_of(32'h8000_001C));
    fetch_ready_i = 1'b1;
    wait_drain("stall_release", 100);
    expect_fetch(32'h8000_0020, 2, 1'b1);
    grant(2);
    wait_drain("resume", 100);

    // Jump with two reads in flight: both responses dropped.
    rsp_hold = 1'b1;
    expect_fetch(32'h8000_0028, 2, 1'b0);
    grant(2);
    wait_budget("two_outstanding", 50);
    cyc(1);
    check("req_two_outstanding", {31'b0, ibus_req_o}, 32'd0);
    do_jump(32'h0000_0100);
    expect_fetch(32'h0000_0100, 2, 1'b1);
    rsp_hold = 1'b0;
    grant(2);
    wait_drain("jump_inflight", 100);

    // Jump with an ungranted request pending and a word queued.
    fetch_ready_i = 1'b0;
    expect_fetch(32'h0000_0108, 1, 1'b0);
    grant(1);
    wait_drain("prefill", 50);
    cyc(1);
    check("valid_before_jump", {31'b0, fetch_valid_o}, 32'd1);
    do_jump(32'h0000_0200);
    cyc(2);
    check("stale_req", {31'b0, ibus_req_o}, 32'd1);
    check("stale_addr", ibus_addr_o, 32'h0000_010C);
    expect_fetch(32'h0000_010C, 1, 1'b0);
    expect_fetch(32'h0000_0200, 2, 1'b1);
    fetch_ready_i = 1'b1;
    grant(3);
    wait_drain("jump_pending", 100);

    // Reset with two reads outstanding; their late responses must be ignored.
    rsp_hold = 1'b1;
    expect_fetch(32'h0000_0208, 2, 1'b0);
    grant(2);
    wait_budget("pre_reset", 50);
    cyc(1);
    pc_reset_i = 32'h0000_4000;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    cyc(2);
    rst = 1'b1;
    rsp_hold = 1'b0;
    cyc(5);
    check("stale_rsp_valid", {31'b0, fetch_valid_o}, 32'd0);
    check("restart_req", {31'b0, ibus_req_o}, 32'd1);
    check("restart_addr", ibus_addr_o, 32'h0000_4000);
    expect_fetch(32'h0000_4000, 2, 1'b1);
    grant(2);
    wait_drain("restart", 100);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
